// File: rtl/rr_bus_arbiter_if.sv
// rtl/rr_bus_arbiter_if.sv - master request/select lines and arbiter grant/routing outputs
// master modport is the requesting side, slave modport is the arbiter side.
interface rr_bus_arbiter_if;
  logic       m1_request;
  logic       m2_request;
  logic       m1_slave_sel;
  logic       m2_slave_sel;
  logic       m1_grant;
  logic       m2_grant;
  logic       arbiter_busy;
  logic [1:0] bus_grant;
  logic [1:0] slave_sel;
  logic       timeout;

  modport master (
    output m1_request, m2_request, m1_slave_sel, m2_slave_sel,
    input  m1_grant, m2_grant, arbiter_busy, bus_grant, slave_sel, timeout
  );

  modport slave (
    input  m1_request, m2_request, m1_slave_sel, m2_slave_sel,
    output m1_grant, m2_grant, arbiter_busy, bus_grant, slave_sel, timeout
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - two-master round-robin bus arbiter with serial 2-bit slave select
// Optional watchdog forced release is enabled by defining ARB_TIMEOUT_EN.
module rr_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  rr_bus_arbiter_if.slave bus
);

  generate
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) || (CNT_W < 1) ||
        ((CNT_W < 32) && ((TIMEOUT_CYCLES >> CNT_W) != 0))) begin : g_bad_cfg
      $error("rr_bus_arbiter: TIMEOUT_CYCLES out of range or does not fit in CNT_W bits");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL_HI,
    S_SEL_LO,
    S_CONNECTED,
    S_RELEASE
  } state_t;

  state_t     state_q, state_d;
  // Master encoding for last/winner: 0 = m1, 1 = m2.
  logic       last_q, last_d;
  logic       winner_q, winner_d;
  logic       code_hi_q, code_hi_d;
  logic       m1_grant_q, m1_grant_d;
  logic       m2_grant_q, m2_grant_d;
  logic       busy_q, busy_d;
  logic [1:0] bus_grant_q, bus_grant_d;
  logic [1:0] slave_sel_q, slave_sel_d;
  logic       timeout_q, timeout_d;

  logic       win_req;
  logic       win_sel;
  logic [1:0] code;

  assign win_req = winner_q ? bus.m2_request   : bus.m1_request;
  assign win_sel = winner_q ? bus.m2_slave_sel : bus.m1_slave_sel;
  assign code    = {code_hi_q, win_sel};

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    winner_d    = winner_q;
    code_hi_d   = code_hi_q;
    m1_grant_d  = m1_grant_q;
    m2_grant_d  = m2_grant_q;
    busy_d      = busy_q;
    bus_grant_d = bus_grant_q;
    slave_sel_d = slave_sel_q;
    timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.m1_request || bus.m2_request) begin
          // Pointer only moves on a genuine tie; a lone requester just wins.
          if (bus.m1_request && bus.m2_request) begin
            winner_d = ~last_q;
            last_d   = ~last_q;
          end else begin
            winner_d = bus.m2_request;
          end
          m1_grant_d = ~winner_d;
          m2_grant_d = winner_d;
          busy_d     = 1'b1;
          state_d    = S_SEL_HI;
        end
      end
      S_SEL_HI: begin
        code_hi_d = win_sel;
        state_d   = S_SEL_LO;
      end
      S_SEL_LO: begin
        if (code != 2'b00) begin
          slave_sel_d = code;
          bus_grant_d = winner_q ? 2'b10 : 2'b01;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = S_CONNECTED;
        end else begin
          m1_grant_d = 1'b0;
          m2_grant_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end
      S_CONNECTED: begin
        if (!win_req) begin
          m1_grant_d  = 1'b0;
          m2_grant_d  = 1'b0;
          bus_grant_d = 2'b00;
          slave_sel_d = 2'b00;
          state_d     = S_RELEASE;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
          // Forced release hands priority to the other master.
          m1_grant_d  = 1'b0;
          m2_grant_d  = 1'b0;
          bus_grant_d = 2'b00;
          slave_sel_d = 2'b00;
          timeout_d   = 1'b1;
          last_d      = winner_q;
          state_d     = S_RELEASE;
        end else begin
          cnt_d = cnt_inc;
`endif
        end
      end
      S_RELEASE: begin
        m1_grant_d  = 1'b0;
        m2_grant_d  = 1'b0;
        bus_grant_d = 2'b00;
        slave_sel_d = 2'b00;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      winner_q    <= 1'b0;
      code_hi_q   <= 1'b0;
      m1_grant_q  <= 1'b0;
      m2_grant_q  <= 1'b0;
      busy_q      <= 1'b0;
      bus_grant_q <= 2'b00;
      slave_sel_q <= 2'b00;
      timeout_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      winner_q    <= winner_d;
      code_hi_q   <= code_hi_d;
      m1_grant_q  <= m1_grant_d;
      m2_grant_q  <= m2_grant_d;
      busy_q      <= busy_d;
      bus_grant_q <= bus_grant_d;
      slave_sel_q <= slave_sel_d;
      timeout_q   <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.m1_grant     = m1_grant_q;
  assign bus.m2_grant     = m2_grant_q;
  assign bus.arbiter_busy = busy_q;
  assign bus.bus_grant    = bus_grant_q;
  assign bus.slave_sel    = slave_sel_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - self-checking bench for rr_bus_arbiter
// Transaction-level reference model compared every cycle, plus literal checkpoints.
module tb_rr_bus_arbiter;
  localparam int TMO = 8;

  logic sys_clk;
  logic sys_rst;
  int   n_cmp;
  int   n_bad;
  bit   cmp_en;

  rr_bus_arbiter_if arb_bus ();

  rr_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (arb_bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Output vector: {m1_grant, m2_grant, busy, bus_grant[1:0], slave_sel[1:0], timeout}
  logic [7:0] dut_vec;
  logic [7:0] exp_vec;
  assign dut_vec = {arb_bus.m1_grant, arb_bus.m2_grant, arb_bus.arbiter_busy,
                    arb_bus.bus_grant, arb_bus.slave_sel, arb_bus.timeout};

  // Reference model: owner is 0 none / 1 m1 / 2 m2; age counts select bits taken.
  int         mo_owner;
  int         mo_age;
  int         mo_last;
  int         mo_hold;
  logic [1:0] mo_code;
  bit         mo_rel;
  bit         mo_routed;
  bit         mo_pulse;

  function automatic logic req_of(input int m);
    return (m == 1) ? arb_bus.m1_request : arb_bus.m2_request;
  endfunction

  function automatic logic sel_of(input int m);
    return (m == 1) ? arb_bus.m1_slave_sel : arb_bus.m2_slave_sel;
  endfunction

  always @(posedge sys_clk) begin
    mo_pulse <= 1'b0;
    if (sys_rst) begin
      mo_owner  <= 0;
      mo_age    <= 0;
      mo_last   <= 2;
      mo_hold   <= 0;
      mo_code   <= 2'b00;
      mo_rel    <= 1'b0;
      mo_routed <= 1'b0;
    end else if (mo_rel) begin
      mo_rel    <= 1'b0;
      mo_owner  <= 0;
      mo_routed <= 1'b0;
    end else if (mo_owner == 0) begin
      mo_age <= 0;
      if (req_of(1) && req_of(2)) begin
        mo_owner <= 3 - mo_last;
        mo_last  <= 3 - mo_last;
      end else if (req_of(1)) begin
        mo_owner <= 1;
      end else if (req_of(2)) begin
        mo_owner <= 2;
      end
    end else if (mo_age == 0) begin
      mo_code <= {sel_of(mo_owner), 1'b0};
      mo_age  <= 1;
    end else if (mo_age == 1) begin
      mo_age <= 2;
      if ({mo_code[1], sel_of(mo_owner)} == 2'b00) begin
        mo_rel <= 1'b1;
      end else begin
        mo_code   <= {mo_code[1], sel_of(mo_owner)};
        mo_routed <= 1'b1;
        mo_hold   <= 0;
      end
    end else if (!req_of(mo_owner)) begin
      mo_rel <= 1'b1;
`ifdef ARB_TIMEOUT_EN
    end else if (mo_hold + 1 >= TMO) begin
      mo_rel   <= 1'b1;
      mo_pulse <= 1'b1;
      mo_last  <= mo_owner;
    end else begin
      mo_hold <= mo_hold + 1;
`endif
    end
  end

  always_comb begin
    exp_vec      = 8'h00;
    exp_vec[7]   = (mo_owner == 1) && !mo_rel;
    exp_vec[6]   = (mo_owner == 2) && !mo_rel;
    exp_vec[5]   = (mo_owner != 0);
    exp_vec[4:3] = (mo_routed && !mo_rel) ? mo_owner[1:0] : 2'b00;
    exp_vec[2:1] = (mo_routed && !mo_rel) ? mo_code : 2'b00;
    exp_vec[0]   = mo_pulse;
  end

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      n_cmp = n_cmp + 1;
      if (dut_vec !== exp_vec) begin
        n_bad = n_bad + 1;
        $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, dut_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    cmp_en = 1'b0;
    sys_rst = 1'b1;
    arb_bus.m1_request   = 1'b0;
    arb_bus.m2_request   = 1'b0;
    arb_bus.m1_slave_sel = 1'b0;
    arb_bus.m2_slave_sel = 1'b0;
    tick(1);
    cmp_en = 1'b1;
    tick(1);
    chk("reset_all_zero", dut_vec, 8'b0000_0000);
    sys_rst = 1'b0;
    tick(1);

    // m1 alone, code 10
    arb_bus.m1_request   = 1'b1;
    arb_bus.m1_slave_sel = 1'b1;
    tick(1);
    chk("t1_grant_latency", dut_vec, 8'b1010_0000);
    tick(1);
    arb_bus.m1_slave_sel = 1'b0;
    tick(1);
    chk("t1_connected_s2", dut_vec, 8'b1010_1100);
    tick(2);
    arb_bus.m1_request = 1'b0;
    tick(1);
    chk("t1_release", dut_vec, 8'b0010_0000);
    tick(1);
    chk("t1_idle", dut_vec, 8'b0000_0000);

    // Tie: m1 first, then m2, then m1 again
    arb_bus.m1_request   = 1'b1;
    arb_bus.m2_request   = 1'b1;
    arb_bus.m1_slave_sel = 1'b0;
    arb_bus.m2_slave_sel = 1'b1;
    tick(1);
    chk("t2_tie_m1_wins", dut_vec, 8'b1010_0000);
    tick(1);
    arb_bus.m1_slave_sel = 1'b1;
    tick(1);
    chk("t2_m1_s1", dut_vec, 8'b1010_1010);
    arb_bus.m1_request = 1'b0;
    tick(1);
    arb_bus.m1_request = 1'b1;
    tick(2);
    chk("t2_tie_m2_wins", dut_vec, 8'b0110_0000);
    tick(2);
    chk("t2_m2_s3", dut_vec, 8'b0111_0110);
    arb_bus.m2_request = 1'b0;
    tick(3);
    chk("t2_m1_again", dut_vec, 8'b1010_0000);
    tick(2);
    arb_bus.m1_request = 1'b0;
    tick(2);

    // m2 invalid code 00: abort
    arb_bus.m2_request   = 1'b1;
    arb_bus.m2_slave_sel = 1'b0;
    tick(1);
    chk("t3_m2_grant", dut_vec, 8'b0110_0000);
    tick(2);
    chk("t3_abort_release", dut_vec, 8'b0010_0000);
    arb_bus.m2_request = 1'b0;
    tick(1);
    chk("t3_idle", dut_vec, 8'b0000_0000);

    // m1 to s3, reset mid-transaction
    arb_bus.m1_request   = 1'b1;
    arb_bus.m1_slave_sel = 1'b1;
    tick(3);
    chk("t4_m1_s3", dut_vec, 8'b1010_1110);
    sys_rst = 1'b1;
    tick(1);
    chk("t4_mid_reset", dut_vec, 8'b0000_0000);
    sys_rst = 1'b0;
    tick(1);
    chk("t4_rearbitrate", dut_vec, 8'b1010_0000);
    tick(2);
    arb_bus.m1_request = 1'b0;
    tick(2);

    // Hold with m2 pending: watchdog release when enabled
    arb_bus.m1_request   = 1'b1;
    arb_bus.m2_request   = 1'b1;
    arb_bus.m1_slave_sel = 1'b1;
    arb_bus.m2_slave_sel = 1'b1;
    tick(1);
    chk("t5_m1_grant", dut_vec, 8'b1010_0000);
    tick(2);
    tick(7);
    chk("t5_still_connected", dut_vec, 8'b1010_1110);
    tick(1);
`ifdef ARB_TIMEOUT_EN
    chk("t5_timeout_pulse", dut_vec, 8'b0010_0001);
    tick(1);
    chk("t5_timeout_clear", dut_vec, 8'b0000_0000);
    tick(1);
    chk("t5_m2_after_timeout", dut_vec, 8'b0110_0000);
`else
    chk("t5_no_watchdog", dut_vec, 8'b1010_1110);
    arb_bus.m1_request = 1'b0;
    tick(1);
    chk("t5_release", dut_vec, 8'b0010_0000);
    tick(2);
    chk("t5_m2_next", dut_vec, 8'b0110_0000);
`endif
    arb_bus.m1_request = 1'b0;
    arb_bus.m2_request = 1'b0;
    tick(6);

    // m1 drops request during SEL_HI
    arb_bus.m1_request   = 1'b1;
    arb_bus.m1_slave_sel = 1'b1;
    tick(1);
    chk("t6_grant", dut_vec, 8'b1010_0000);
    arb_bus.m1_request = 1'b0;
    tick(2);
    chk("t6_connected_once", dut_vec, 8'b1010_1110);
    tick(1);
    chk("t6_release", dut_vec, 8'b0010_0000);
    tick(1);
    chk("t6_idle", dut_vec, 8'b0000_0000);
    tick(2);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
